// File: rtl/vic_pkg.sv
// vic_pkg: shared FSM state encoding and constant clog2 helper for the interrupt controller.
package vic_pkg;
    typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_e;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/vic_prio_enc.sv
// vic_prio_enc: fixed-priority encoder, lowest set index wins.
module vic_prio_enc #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) idx_o = req_i[i] ? W'(i) : idx_o;
    end

    assign valid_o = |req_i;
endmodule

// File: rtl/prio_vic.sv
// prio_vic: vectored interrupt controller with synchronised edge/level inputs,
// fixed-priority arbitration and an optional assert timeout.
module prio_vic import vic_pkg::*; #(
    parameter int INT_NUM   = 16,
    parameter int INT_WIDTH = 8,
    parameter int ID_W      = clog2(INT_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INT_NUM-1:0] int_source,
    input  logic [INT_NUM-1:0] int_mask,
    input  logic [INT_NUM-1:0] int_edge,
    input  logic [INT_NUM-1:0] int_clr,
    input  logic               int_ack,
    output logic               vic_int,
    output logic [ID_W-1:0]    vic_id,
    output logic [INT_NUM-1:0] int_pend,
    output logic [INT_NUM-1:0] int_active
);
    localparam int CW = INT_WIDTH > 0 ? INT_WIDTH : 1;

    logic [INT_NUM-1:0] s1_q, s2_q, h_q, pulse, sel, ack_clr, pend_d;
    logic [2:0]         warm_q;
    logic [CW-1:0]      cnt_q;
    logic [ID_W-1:0]    win_id;
    logic               win_v, timeout;
    state_e             state_q;

    vic_prio_enc #(.N(INT_NUM), .W(ID_W)) u_enc (
        .req_i  (int_pend & int_mask),
        .idx_o  (win_id),
        .valid_o(win_v)
    );

    // Edges are suppressed until history has caught up after reset, so lines
    // already high at release do not look like fresh edges.
    assign pulse   = s2_q & ~h_q & {INT_NUM{warm_q[2]}};
    assign sel     = INT_NUM'(1) << vic_id;
    assign ack_clr = (state_q == ASSERT && int_ack) ? sel & int_edge : '0;
    assign pend_d  = (int_edge & ((int_pend & ~int_clr & ~ack_clr) | pulse)) | (~int_edge & s2_q);
    assign timeout = (INT_WIDTH > 0) && (&cnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            h_q      <= '0;
            warm_q   <= '0;
            int_pend <= '0;
        end else begin
            s1_q     <= int_source;
            s2_q     <= s1_q;
            h_q      <= s2_q;
            warm_q   <= {warm_q[1:0], 1'b1};
            int_pend <= pend_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            vic_int    <= 1'b0;
            vic_id     <= '0;
            int_active <= '0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (win_v) begin
                    vic_id  <= win_id;
                    vic_int <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= ASSERT;
                end
                ASSERT: if (int_ack) begin
                    int_active <= sel;
                    vic_int    <= 1'b0;
                    cnt_q      <= '0;
                    state_q    <= SERVICE;
                end else if (!(int_pend[vic_id] && int_mask[vic_id]) || timeout) begin
                    vic_int <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                SERVICE: if (int_clr[vic_id]) begin
                    int_active <= '0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prio_vic.sv
// tb_prio_vic: scoreboard bench; expected vector ids are queued at stimulus time
// and popped on each rising vic_int.
module tb_prio_vic;
    logic        clk = 0, rst = 1, int_ack = 0;
    logic [15:0] int_source = '0, int_mask = '1, int_edge = '1, int_clr = '0;
    logic        vic_int;
    logic [3:0]  vic_id;
    logic [15:0] int_pend, int_active;

    typedef struct {string tag; int id;} exp_t;
    exp_t exp_q[$];
    int   checks = 0, failures = 0;
    logic prev_int = 0;

    always #5 clk = ~clk;

    prio_vic #(.INT_NUM(16), .INT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .int_source(int_source), .int_mask(int_mask),
        .int_edge(int_edge), .int_clr(int_clr), .int_ack(int_ack),
        .vic_int(vic_int), .vic_id(vic_id), .int_pend(int_pend), .int_active(int_active)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (vic_int && !prev_int) begin
            exp_t e;
            if (exp_q.size() == 0) check("sb_unexpected_int", 1, 0);
            else begin
                e = exp_q.pop_front();
                check(e.tag, 64'(vic_id), 64'(e.id));
            end
        end
        prev_int = vic_int;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_int;
        int n = 0;
        while (!vic_int && n < 40) begin
            tick;
            n++;
        end
        check("wait_int", vic_int, 1);
    endtask

    task automatic serve(input int id);
        wait_int;
        check("serve_id", vic_id, id);
        int_ack = 1;
        tick;
        int_ack = 0;
        check("serve_active", int_active, 16'(1) << id);
        int_clr = 16'(1) << id;
        tick;
        int_clr = '0;
        check("serve_eoi", int_active, 0);
    endtask

    initial begin
        int n;
        repeat (3) tick;
        check("rst_int", vic_int, 0);
        check("rst_id", vic_id, 0);
        check("rst_pend", int_pend, 0);
        check("rst_active", int_active, 0);
        rst = 0;
        repeat (5) tick;

        // edge ch3 latency, ack and EOI
        exp_q.push_back('{"id_ch3", 3});
        int_source[3] = 1;
        repeat (3) tick;
        check("lat3_int", vic_int, 0);
        check("lat3_pend", int_pend[3], 1);
        int_source[3] = 0;
        tick;
        check("lat4_int", vic_int, 1);
        int_ack = 1;
        tick;
        int_ack = 0;
        check("ack3_int", vic_int, 0);
        check("ack3_pend", int_pend[3], 0);
        check("ack3_active", int_active, 16'h0008);
        int_clr[3] = 1;
        tick;
        int_clr = '0;
        check("eoi3_active", int_active, 0);
        tick;
        check("eoi3_idle", vic_int, 0);

        // simultaneous ch5 and ch2
        exp_q.push_back('{"id_ch2_first", 2});
        exp_q.push_back('{"id_ch5_second", 5});
        int_source[2] = 1;
        int_source[5] = 1;
        tick;
        int_source = '0;
        serve(2);
        serve(5);

        // level ch7 timeout and re-arbitration
        int_edge[7] = 0;
        exp_q.push_back('{"id_ch7", 7});
        exp_q.push_back('{"id_ch7_rearm", 7});
        int_source[7] = 1;
        wait_int;
        n = 0;
        while (vic_int && n < 40) begin
            n++;
            tick;
        end
        check("to_high_cycles", n, 16);
        check("to_pend_kept", int_pend[7], 1);
        tick;
        check("to_reassert", vic_int, 1);
        check("to_reassert_id", vic_id, 7);
        int_source[7] = 0;
        repeat (6) tick;
        check("lvl_drop_int", vic_int, 0);
        check("lvl_drop_pend", int_pend[7], 0);
        int_edge[7] = 1;

        // mask cleared during ASSERT
        exp_q.push_back('{"id_ch1", 1});
        exp_q.push_back('{"id_ch1_unmask", 1});
        int_source[1] = 1;
        tick;
        int_source[1] = 0;
        wait_int;
        int_mask[1] = 0;
        tick;
        check("mask_drop_int", vic_int, 0);
        check("mask_pend_kept", int_pend[1], 1);
        check("mask_active", int_active, 0);
        tick;
        check("mask_stay_idle", vic_int, 0);
        int_mask[1] = 1;
        serve(1);

        // clear and new edge same cycle; ack in IDLE
        int_mask[4] = 0;
        int_source[4] = 1;
        repeat (2) tick;
        int_clr[4] = 1;
        tick;
        int_clr = '0;
        check("clr_vs_set", int_pend[4], 1);
        int_source[4] = 0;
        int_clr[4] = 1;
        tick;
        int_clr = '0;
        check("clr_only", int_pend[4], 0);
        int_ack = 1;
        tick;
        int_ack = 0;
        check("idle_ack_int", vic_int, 0);
        check("idle_ack_active", int_active, 0);
        tick;
        check("idle_ack_stay", vic_int, 0);
        int_mask[4] = 1;

        // reset during SERVICE
        exp_q.push_back('{"id_ch6", 6});
        int_source[6] = 1;
        tick;
        int_source[6] = 0;
        wait_int;
        int_ack = 1;
        tick;
        int_ack = 0;
        check("svc6_active", int_active, 16'h0040);
        int_edge[0] = 0;
        int_source[0] = 1;
        int_source[9] = 1;
        #3 rst = 1;
        #1;
        check("arst_int", vic_int, 0);
        check("arst_id", vic_id, 0);
        check("arst_pend", int_pend, 0);
        check("arst_active", int_active, 0);
        repeat (2) tick;
        rst = 0;
        exp_q.push_back('{"id_ch0_after_rst", 0});
        repeat (3) tick;
        check("rst_lvl_repend", int_pend, 16'h0001);
        check("rst_lvl_int_lat", vic_int, 0);
        tick;
        check("rst_lvl_assert", vic_int, 1);
        int_ack = 1;
        tick;
        int_ack = 0;
        check("rst_lvl_active", int_active, 16'h0001);
        int_source[0] = 0;
        int_source[9] = 0;
        repeat (5) tick;
        check("rst_no_edge9", int_pend, 0);
        int_clr[0] = 1;
        tick;
        int_clr = '0;
        check("rst_lvl_eoi", int_active, 0);
        repeat (3) tick;
        check("final_idle", vic_int, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
